// File: rtl/exe_pkg.sv
// Shared encodings for the execute/memory stage: access sizes, fault codes, FSM states, ALU opcodes.
// Constants only; no logic.
package exe_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic [1:0] FLT_NONE  = 2'b00;
  localparam logic [1:0] FLT_MISAL = 2'b01;
  localparam logic [1:0] FLT_BUS   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU, zero latency, no flow control.
// Used for both ALU results and load/store address generation (forced to ADD).
module alu
  import exe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] y_o
);

  localparam int SW = $clog2(XLEN);

  logic [SW-1:0] shamt;
  assign shamt = b_i[SW-1:0];

  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_ADD:   y_o = a_i + b_i;
      ALU_SUB:   y_o = a_i - b_i;
      ALU_SLL:   y_o = a_i << shamt;
      ALU_SLT:   y_o = XLEN'($signed(a_i) < $signed(b_i));
      ALU_SLTU:  y_o = XLEN'(a_i < b_i);
      ALU_XOR:   y_o = a_i ^ b_i;
      ALU_SRL:   y_o = a_i >> shamt;
      ALU_SRA:   y_o = $signed(a_i) >>> shamt;
      ALU_OR:    y_o = a_i | b_i;
      ALU_AND:   y_o = a_i & b_i;
      ALU_PASSB: y_o = b_i;
      default:   y_o = '0;
    endcase
  end

endmodule

// File: rtl/exe_lsu_stage.sv
// Registered execute/memory stage: ALU ops in 1 cycle, loads/stores via req/ack bus (min 2 cycles).
// Single entry: accepts only when idle and the output slot is empty or draining; output held while stalled.
module exe_lsu_stage
  import exe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [4:0]        rd_ptr_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic [XLEN-1:0]   rs2_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [3:0]        alu_opcode_i,
  input  logic              alu_src_i,
  input  logic              reg_we_i,
  input  logic              mem_we_i,
  input  logic              mem_re_i,
  input  logic [1:0]        mem_hb_i,
  input  logic              mem_ul_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   rd_o,
  output logic [4:0]        rd_ptr_o,
  output logic              reg_we_o,
  output logic [1:0]        fault_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [XLEN-1:0]   bus_addr_o,
  output logic [XLEN-1:0]   bus_wdata_o,
  output logic [XLEN/8-1:0] bus_be_o,
  input  logic [XLEN-1:0]   bus_rdata_i,
  input  logic              bus_ack_i,
  input  logic              bus_err_i
);

  localparam int NB = XLEN / 8;
  localparam int LW = $clog2(NB);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  function automatic logic [XLEN-1:0] size_mask(input logic [1:0] hb);
    case (hb)
      SZ_B:    size_mask = XLEN'(8'hFF);
      SZ_H:    size_mask = XLEN'(16'hFFFF);
      SZ_W:    size_mask = XLEN'(32'hFFFF_FFFF);
      default: size_mask = '1;
    endcase
  endfunction

  function automatic logic [NB-1:0] gen_be(input logic [1:0] hb, input logic [LW-1:0] lane);
    logic [NB-1:0] m;
    case (hb)
      SZ_B:    m = NB'(1'b1);
      SZ_H:    m = NB'(2'b11);
      SZ_W:    m = NB'(4'hF);
      default: m = '1;
    endcase
    return m << lane;
  endfunction

  // Doubleword is only legal on a 64-bit datapath; elsewhere it reports as misaligned.
  function automatic logic misaligned(input logic [1:0] hb, input logic [2:0] a);
    case (hb)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = a[0];
      SZ_W:    misaligned = |a[1:0];
      default: misaligned = (XLEN != 64) || (|a[2:0]);
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] data, input logic [LW-1:0] lane,
                                               input logic [1:0] hb, input logic ul);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] keep;
    logic            sb;
    sh   = data >> {lane, 3'b000};
    keep = size_mask(hb);
    case (hb)
      SZ_B:    sb = sh[7];
      SZ_H:    sb = sh[15];
      SZ_W:    sb = sh[31];
      default: sb = 1'b0;
    endcase
    return (sh & keep) | (~keep & {XLEN{sb & ~ul}});
  endfunction

  state_e          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] rd_q, rd_d;
  logic [4:0]      rd_ptr_q, rd_ptr_d;
  logic            reg_we_q, reg_we_d;
  logic [1:0]      fault_q, fault_d;
  logic            bus_req_q, bus_req_d;
  logic            bus_we_q, bus_we_d;
  logic [XLEN-1:0] bus_addr_q, bus_addr_d;
  logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;
  logic [NB-1:0]   bus_be_q, bus_be_d;
  logic [TW-1:0]   timer_q, timer_d, timer_inc;
  logic [1:0]      hb_q, hb_d;
  logic            ul_q, ul_d;
  logic            is_load_q, is_load_d;

  logic            is_mem, accept;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] alu_b, alu_y;

  assign is_mem     = mem_we_i | mem_re_i;
  assign alu_op     = is_mem ? ALU_ADD : alu_opcode_i;
  assign alu_b      = alu_src_i ? imm_i : rs2_i;
  assign in_ready_o = (state_q == ST_IDLE) & (~out_valid_q | out_ready_i);
  assign accept     = in_valid_i & in_ready_o;
  assign timer_inc  = timer_q + 1'b1;

  alu #(.XLEN(XLEN)) u_alu (
    .op_i (alu_op),
    .a_i  (rs1_i),
    .b_i  (alu_b),
    .y_o  (alu_y)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    rd_d        = rd_q;
    rd_ptr_d    = rd_ptr_q;
    reg_we_d    = reg_we_q;
    fault_d     = fault_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    timer_d     = timer_q;
    hb_d        = hb_q;
    ul_d        = ul_q;
    is_load_d   = is_load_q;
    case (state_q)
      ST_IDLE: begin
        if (out_ready_i) out_valid_d = 1'b0;
        if (accept) begin
          rd_ptr_d = rd_ptr_i;
          fault_d  = FLT_NONE;
          if (!is_mem) begin
            out_valid_d = 1'b1;
            rd_d        = alu_y;
            reg_we_d    = reg_we_i;
          end else if (misaligned(mem_hb_i, alu_y[2:0])) begin
            out_valid_d = 1'b1;
            rd_d        = '0;
            reg_we_d    = 1'b0;
            fault_d     = FLT_MISAL;
          end else begin
            state_d     = ST_BUS;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_we_i;
            bus_addr_d  = alu_y;
            bus_be_d    = gen_be(mem_hb_i, alu_y[LW-1:0]);
            bus_wdata_d = (rs2_i & size_mask(mem_hb_i)) << {alu_y[LW-1:0], 3'b000};
            timer_d     = '0;
            hb_d        = mem_hb_i;
            ul_d        = mem_ul_i;
            is_load_d   = ~mem_we_i;
            reg_we_d    = reg_we_i & ~mem_we_i;
          end
        end
      end
      ST_BUS: begin
        timer_d = timer_inc;
        if (bus_err_i || (!bus_ack_i && TIMEOUT != 0 && timer_inc == TW'(TIMEOUT))) begin
          state_d     = ST_RESP;
          bus_req_d   = 1'b0;
          out_valid_d = 1'b1;
          rd_d        = '0;
          reg_we_d    = 1'b0;
          fault_d     = FLT_BUS;
        end else if (bus_ack_i) begin
          state_d     = ST_RESP;
          bus_req_d   = 1'b0;
          out_valid_d = 1'b1;
          rd_d        = is_load_q ? load_ext(bus_rdata_i, bus_addr_q[LW-1:0], hb_q, ul_q) : '0;
        end
      end
      ST_RESP: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      rd_q        <= '0;
      rd_ptr_q    <= '0;
      reg_we_q    <= 1'b0;
      fault_q     <= FLT_NONE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      timer_q     <= '0;
      hb_q        <= SZ_B;
      ul_q        <= 1'b0;
      is_load_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      rd_q        <= rd_d;
      rd_ptr_q    <= rd_ptr_d;
      reg_we_q    <= reg_we_d;
      fault_q     <= fault_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      timer_q     <= timer_d;
      hb_q        <= hb_d;
      ul_q        <= ul_d;
      is_load_q   <= is_load_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign rd_o        = rd_q;
  assign rd_ptr_o    = rd_ptr_q;
  assign reg_we_o    = reg_we_q;
  assign fault_o     = fault_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_be_o    = bus_be_q;

endmodule

// File: tb/tb_exe_lsu_stage.sv
// Directed bench for exe_lsu_stage (XLEN=32, TIMEOUT=4): ALU vector table plus hand-written
// load/store, fault, backpressure and reset sequences.
module tb_exe_lsu_stage;
  import exe_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [4:0]  rd_ptr_i;
  logic [31:0] rs1_i, rs2_i, imm_i;
  logic [3:0]  alu_opcode_i;
  logic        alu_src_i, reg_we_i, mem_we_i, mem_re_i, mem_ul_i;
  logic [1:0]  mem_hb_i;
  logic        out_valid_o, out_ready_i;
  logic [31:0] rd_o;
  logic [4:0]  rd_ptr_o;
  logic        reg_we_o;
  logic [1:0]  fault_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i, bus_err_i;

  int errors = 0;
  int checks = 0;

  exe_lsu_stage #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .rd_ptr_i(rd_ptr_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
    .alu_opcode_i(alu_opcode_i), .alu_src_i(alu_src_i), .reg_we_i(reg_we_i),
    .mem_we_i(mem_we_i), .mem_re_i(mem_re_i), .mem_hb_i(mem_hb_i), .mem_ul_i(mem_ul_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .rd_o(rd_o), .rd_ptr_o(rd_ptr_o),
    .reg_we_o(reg_we_o), .fault_o(fault_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        src;
    logic        we;
    logic [4:0]  rp;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mem_op(input logic we, input logic [1:0] hb, input logic ul, input logic [31:0] base,
                        input logic [31:0] off, input logic [31:0] data, input logic [4:0] rp);
    in_valid_i   = 1'b1;
    mem_we_i     = we;
    mem_re_i     = ~we;
    mem_hb_i     = hb;
    mem_ul_i     = ul;
    rs1_i        = base;
    imm_i        = off;
    rs2_i        = data;
    alu_src_i    = 1'b1;
    alu_opcode_i = ALU_XOR;
    rd_ptr_i     = rp;
    reg_we_i     = 1'b1;
    tick();
    in_valid_i = 1'b0;
    mem_we_i   = 1'b0;
    mem_re_i   = 1'b0;
  endtask

  task automatic load_byte(input logic ul, input logic [31:0] exp);
    mem_op(1'b0, SZ_B, ul, 32'h0FF, 32'h4, 32'h0, 5'd3);
    chk("ldb_req", 32'(bus_req_o), 32'd1);
    chk("ldb_be", 32'(bus_be_o), 32'b1000);
    chk("ldb_addr", bus_addr_o, 32'h103);
    chk("ldb_we", 32'(bus_we_o), 32'd0);
    chk("ldb_rdy_busy", 32'(in_ready_o), 32'd0);
    tick();
    chk("ldb_req_hold", 32'(bus_req_o), 32'd1);
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h8000_0000;
    tick();
    bus_ack_i = 1'b0;
    chk("ldb_vld", 32'(out_valid_o), 32'd1);
    chk("ldb_rd", rd_o, exp);
    chk("ldb_regwe", 32'(reg_we_o), 32'd1);
    chk("ldb_fault", 32'(fault_o), 32'(FLT_NONE));
    chk("ldb_req_drop", 32'(bus_req_o), 32'd0);
    chk("ldb_rdptr", 32'(rd_ptr_o), 32'd3);
    tick();
    chk("ldb_drain", 32'(out_valid_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{ALU_ADD,   32'd5,          32'd7,      32'd0,          1'b0, 1'b1, 5'd1,  32'd12};
    vecs[1]  = '{ALU_SUB,   32'd5,          32'd7,      32'd0,          1'b0, 1'b1, 5'd2,  32'hFFFF_FFFE};
    vecs[2]  = '{ALU_ADD,   32'h100,        32'h999,    32'h20,         1'b1, 1'b0, 5'd3,  32'h120};
    vecs[3]  = '{ALU_AND,   32'hF0F0,       32'hFF00,   32'd0,          1'b0, 1'b1, 5'd4,  32'hF000};
    vecs[4]  = '{ALU_OR,    32'hF000,       32'h000F,   32'd0,          1'b0, 1'b1, 5'd5,  32'hF00F};
    vecs[5]  = '{ALU_XOR,   32'hFF00,       32'h0FF0,   32'd0,          1'b0, 1'b1, 5'd6,  32'hF0F0};
    vecs[6]  = '{ALU_SLL,   32'd1,          32'd4,      32'd0,          1'b0, 1'b1, 5'd7,  32'd16};
    vecs[7]  = '{ALU_SRA,   32'h8000_0000,  32'd4,      32'd0,          1'b0, 1'b1, 5'd8,  32'hF800_0000};
    vecs[8]  = '{ALU_SRL,   32'h8000_0000,  32'd4,      32'd0,          1'b0, 1'b1, 5'd9,  32'h0800_0000};
    vecs[9]  = '{ALU_SLT,   32'hFFFF_FFFF,  32'd0,      32'd0,          1'b0, 1'b1, 5'd10, 32'd1};
    vecs[10] = '{ALU_SLTU,  32'hFFFF_FFFF,  32'd0,      32'd0,          1'b0, 1'b1, 5'd31, 32'd0};

    rst_i = 1'b1; in_valid_i = 1'b0; rd_ptr_i = '0; rs1_i = '0; rs2_i = '0; imm_i = '0;
    alu_opcode_i = ALU_ADD; alu_src_i = 1'b0; reg_we_i = 1'b0; mem_we_i = 1'b0; mem_re_i = 1'b0;
    mem_hb_i = SZ_B; mem_ul_i = 1'b0; out_ready_i = 1'b1; bus_rdata_i = '0; bus_ack_i = 1'b0; bus_err_i = 1'b0;
    tick();
    tick();
    chk("rst_vld", 32'(out_valid_o), 32'd0);
    chk("rst_req", 32'(bus_req_o), 32'd0);
    chk("rst_rd", rd_o, 32'd0);
    chk("rst_be", 32'(bus_be_o), 32'd0);
    chk("rst_fault", 32'(fault_o), 32'd0);
    rst_i = 1'b0;
    #1;
    chk("rst_rdy", 32'(in_ready_o), 32'd1);

    // Back-to-back ALU ops: a new instruction every cycle, result one cycle later.
    for (int i = 0; i < 11; i++) begin
      in_valid_i = 1'b1; alu_opcode_i = vecs[i].op; rs1_i = vecs[i].a; rs2_i = vecs[i].b;
      imm_i = vecs[i].imm; alu_src_i = vecs[i].src; reg_we_i = vecs[i].we; rd_ptr_i = vecs[i].rp;
      #1;
      chk($sformatf("alu%0d_rdy", i), 32'(in_ready_o), 32'd1);
      tick();
      chk($sformatf("alu%0d_vld", i), 32'(out_valid_o), 32'd1);
      chk($sformatf("alu%0d_rd", i), rd_o, vecs[i].exp);
      chk($sformatf("alu%0d_ptr", i), 32'(rd_ptr_o), 32'(vecs[i].rp));
      chk($sformatf("alu%0d_we", i), 32'(reg_we_o), 32'(vecs[i].we));
    end
    in_valid_i = 1'b0;
    tick();
    chk("alu_drain", 32'(out_valid_o), 32'd0);

    load_byte(1'b0, 32'hFFFF_FF80);
    load_byte(1'b1, 32'h0000_0080);

    // Store half, acked in the same cycle the request rises.
    mem_op(1'b1, SZ_H, 1'b0, 32'h100, 32'h2, 32'h1234, 5'd4);
    chk("sth_req", 32'(bus_req_o), 32'd1);
    chk("sth_be", 32'(bus_be_o), 32'b1100);
    chk("sth_wdata", bus_wdata_o, 32'h1234_0000);
    chk("sth_we", 32'(bus_we_o), 32'd1);
    bus_ack_i = 1'b1;
    tick();
    bus_ack_i = 1'b0;
    chk("sth_vld", 32'(out_valid_o), 32'd1);
    chk("sth_regwe", 32'(reg_we_o), 32'd0);
    chk("sth_rd", rd_o, 32'd0);
    chk("sth_fault", 32'(fault_o), 32'(FLT_NONE));
    tick();

    mem_op(1'b0, SZ_W, 1'b0, 32'h100, 32'h1, 32'h0, 5'd5);
    chk("misw_req", 32'(bus_req_o), 32'd0);
    chk("misw_vld", 32'(out_valid_o), 32'd1);
    chk("misw_fault", 32'(fault_o), 32'(FLT_MISAL));
    chk("misw_regwe", 32'(reg_we_o), 32'd0);
    tick();

    mem_op(1'b0, SZ_D, 1'b0, 32'h100, 32'h0, 32'h0, 5'd6);
    chk("dw32_req", 32'(bus_req_o), 32'd0);
    chk("dw32_fault", 32'(fault_o), 32'(FLT_MISAL));
    tick();

    // No ack: request held exactly TIMEOUT=4 cycles.
    mem_op(1'b0, SZ_W, 1'b0, 32'h200, 32'h0, 32'h0, 5'd7);
    chk("to_req0", 32'(bus_req_o), 32'd1);
    for (int c = 1; c < 4; c++) begin
      tick();
      chk($sformatf("to_req%0d", c), 32'(bus_req_o), 32'd1);
      chk($sformatf("to_vld%0d", c), 32'(out_valid_o), 32'd0);
    end
    tick();
    chk("to_req_drop", 32'(bus_req_o), 32'd0);
    chk("to_vld", 32'(out_valid_o), 32'd1);
    chk("to_fault", 32'(fault_o), 32'(FLT_BUS));
    chk("to_regwe", 32'(reg_we_o), 32'd0);
    tick();

    mem_op(1'b0, SZ_W, 1'b0, 32'h204, 32'h0, 32'h0, 5'd8);
    bus_err_i = 1'b1; bus_ack_i = 1'b1; bus_rdata_i = 32'h5555_5555;
    tick();
    bus_err_i = 1'b0; bus_ack_i = 1'b0;
    chk("err_vld", 32'(out_valid_o), 32'd1);
    chk("err_fault", 32'(fault_o), 32'(FLT_BUS));
    chk("err_regwe", 32'(reg_we_o), 32'd0);
    tick();

    bus_ack_i = 1'b1;
    tick();
    bus_ack_i = 1'b0;
    chk("stray_ack_vld", 32'(out_valid_o), 32'd0);
    chk("stray_ack_req", 32'(bus_req_o), 32'd0);

    // Writeback stalls for 3 cycles: result held, no new accept.
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; alu_opcode_i = ALU_ADD; alu_src_i = 1'b0; reg_we_i = 1'b1;
    rs1_i = 32'd1; rs2_i = 32'd2; rd_ptr_i = 5'd11;
    tick();
    chk("bp_vld", 32'(out_valid_o), 32'd1);
    chk("bp_rd", rd_o, 32'd3);
    rs1_i = 32'd10; rs2_i = 32'd20; rd_ptr_i = 5'd12;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp_rdy%0d", c), 32'(in_ready_o), 32'd0);
      tick();
      chk($sformatf("bp_hold_rd%0d", c), rd_o, 32'd3);
      chk($sformatf("bp_hold_ptr%0d", c), 32'(rd_ptr_o), 32'd11);
      chk($sformatf("bp_hold_vld%0d", c), 32'(out_valid_o), 32'd1);
    end
    out_ready_i = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(in_ready_o), 32'd1);
    tick();
    in_valid_i = 1'b0;
    chk("bp_next_rd", rd_o, 32'd30);
    chk("bp_next_ptr", 32'(rd_ptr_o), 32'd12);
    tick();

    // Reset while a store is on the bus: abandoned, nothing emitted.
    mem_op(1'b1, SZ_W, 1'b0, 32'h300, 32'h0, 32'hDEAD_BEEF, 5'd9);
    chk("rbus_req", 32'(bus_req_o), 32'd1);
    chk("rbus_wdata", bus_wdata_o, 32'hDEAD_BEEF);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rbus_req_drop", 32'(bus_req_o), 32'd0);
    chk("rbus_we", 32'(bus_we_o), 32'd0);
    chk("rbus_addr", bus_addr_o, 32'd0);
    chk("rbus_wdata0", bus_wdata_o, 32'd0);
    chk("rbus_be", 32'(bus_be_o), 32'd0);
    chk("rbus_vld", 32'(out_valid_o), 32'd0);
    chk("rbus_fault", 32'(fault_o), 32'd0);
    chk("rbus_rd", rd_o, 32'd0);
    bus_ack_i = 1'b1;
    tick();
    bus_ack_i = 1'b0;
    chk("rbus_noout", 32'(out_valid_o), 32'd0);
    chk("rbus_rdy", 32'(in_ready_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
